// File: rtl/mod_exp_engine.sv
// mod_exp_engine: right-to-left square-and-multiply base^exponent mod modulus on a shared Blakley multiplier.
// Optional EARLY_EXIT_EN stops once the remaining exponent bits are all zero.
module mod_exp_engine #(
  parameter int WIDTH = 6,
  parameter int EXP_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [EXP_WIDTH-1:0] count
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, INIT, MUL, SQR, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, b_q, b_d, n_q, n_d, result_q, result_d;
  logic [EXP_WIDTH-1:0] e_q, e_d, count_q, count_d;
  logic [WIDTH+1:0] p_q, p_d, p_dbl, p_r1, p_r2, n_ext;
  logic [IW-1:0] idx_q, idx_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] op_a;
  logic last_bit;
  assign busy = busy_q;
  assign done = done_q;
  assign result = result_q;
  assign count = count_q;
  assign n_ext = {2'b00, n_q};
  assign op_a = (state_q == MUL) ? acc_q : b_q;
  // 2P + a[i]*m stays below 4*2^WIDTH even for out-of-contract operands
  assign p_dbl = {p_q[WIDTH:0], 1'b0} + (op_a[idx_q] ? {2'b00, b_q} : '0);
  assign p_r1 = (p_dbl >= n_ext) ? p_dbl - n_ext : p_dbl;
  assign p_r2 = (p_r1 >= n_ext) ? p_r1 - n_ext : p_r1;
`ifdef EARLY_EXIT_EN
  assign last_bit = (count_q == EXP_WIDTH'(EXP_WIDTH - 1)) || ((e_q >> 1) == '0);
`else
  assign last_bit = (count_q == EXP_WIDTH'(EXP_WIDTH - 1));
`endif
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    b_d = b_q;
    n_d = n_q;
    e_d = e_q;
    count_d = count_q;
    result_d = result_q;
    p_d = p_q;
    idx_d = idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = INIT;
        busy_d = 1'b1;
        acc_d = WIDTH'(1);
        b_d = base;
        e_d = exponent;
        n_d = modulus;
        count_d = '0;
      end
      INIT: begin
        p_d = '0;
        idx_d = IW'(WIDTH - 1);
        if (n_q < WIDTH'(2)) begin
          state_d = DONE;
          result_d = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
`ifdef EARLY_EXIT_EN
        else if (e_q == '0) begin
          state_d = DONE;
          result_d = acc_q;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
`endif
        else state_d = e_q[0] ? MUL : SQR;
      end
      MUL, SQR: begin
        p_d = p_r2;
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          p_d = '0;
          idx_d = IW'(WIDTH - 1);
          if (state_q == MUL) begin
            acc_d = p_r2[WIDTH-1:0];
            state_d = SQR;
          end else begin
            b_d = p_r2[WIDTH-1:0];
            if (last_bit) begin
              state_d = DONE;
              result_d = acc_q;
              busy_d = 1'b0;
              done_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
              e_d = e_q >> 1;
              state_d = e_q[1] ? MUL : SQR;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      b_q <= '0;
      n_q <= '0;
      e_q <= '0;
      count_q <= '0;
      result_q <= '0;
      p_q <= '0;
      idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      b_q <= b_d;
      n_q <= n_d;
      e_q <= e_d;
      count_q <= count_d;
      result_q <= result_d;
      p_q <= p_d;
      idx_q <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_mod_exp_engine.sv
// tb_mod_exp_engine: scoreboard bench with directed vectors for mod_exp_engine.
module tb_mod_exp_engine;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [5:0] base = '0, exponent = '0, modulus = '0;
  logic busy, done;
  logic [5:0] result, count;
  int cyc = 0, checks = 0, errors = 0;
`ifdef EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  typedef struct {int t; logic [5:0] res; logic [5:0] cnt; bit chk_res;} exp_t;
  typedef struct {int b; int e; int m; int r; int n0; int c0; int n1; int c1; bit chk_res;} vec_t;
  exp_t sb[$];
  vec_t vecs[9];
  mod_exp_engine #(.WIDTH(6), .EXP_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .busy(busy), .done(done), .result(result), .count(count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        x = sb.pop_front();
        chk("done_edge", cyc, x.t);
        if (x.chk_res) chk("result", int'(result), int'(x.res));
        chk("final_count", int'(count), int'(x.cnt));
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end
  task automatic issue(input vec_t v);
    exp_t x;
    @(negedge clk);
    base = 6'(v.b);
    exponent = 6'(v.e);
    modulus = 6'(v.m);
    start = 1'b1;
    x.t = cyc + 1 + (EE ? v.n1 : v.n0);
    x.res = 6'(v.r);
    x.cnt = 6'(EE ? v.c1 : v.c0);
    x.chk_res = v.chk_res;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    base = 6'd1;
    exponent = 6'd1;
    modulus = 6'd5;
    chk("busy_after_start", int'(busy), 1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask
  initial begin
    vecs[0] = '{4, 13, 33, 31, 55, 5, 43, 3, 1'b1};
    vecs[1] = '{5, 0, 7, 1, 37, 5, 1, 0, 1'b1};
    vecs[2] = '{3, 5, 1, 0, 1, 0, 1, 0, 1'b1};
    vecs[3] = '{0, 7, 0, 0, 1, 0, 1, 0, 1'b1};
    vecs[4] = '{2, 10, 31, 1, 49, 5, 37, 3, 1'b1};
    vecs[5] = '{3, 63, 61, 27, 73, 5, 73, 5, 1'b1};
    vecs[6] = '{7, 1, 10, 7, 43, 5, 13, 0, 1'b1};
    vecs[7] = '{6, 32, 35, 1, 43, 5, 43, 5, 1'b1};
    vecs[8] = '{63, 3, 10, 0, 49, 5, 25, 1, 1'b0};
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_count", int'(count), 0);
    reset = 1'b0;
    foreach (vecs[i]) begin
      issue(vecs[i]);
      wait_idle();
      repeat (2) @(negedge clk);
      if (vecs[i].chk_res) chk("result_held", int'(result), vecs[i].r);
    end
    issue(vecs[0]);
    repeat (9) @(negedge clk);
    base = 6'd2;
    exponent = 6'd3;
    modulus = 6'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (60) @(negedge clk);
    chk("no_restart_busy", int'(busy), 0);
    issue(vecs[0]);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrun_reset_busy", int'(busy), 0);
    chk("midrun_reset_result", int'(result), 0);
    chk("midrun_reset_count", int'(count), 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("after_reset_idle_result", int'(result), 0);
    issue(vecs[4]);
    wait_idle();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mod_exp_engine.md
Name: mod_exp_engine

Overview:
- Iterative right-to-left square-and-multiply engine computing result = base^exponent mod modulus.
- Produces `count`, the index of the exponent bit currently being processed. This is the value the loop-control Counter stage compares against the key length to drop its Continue flag.
- Uses one shared bit-serial interleaved (Blakley) modular multiplier for both multiply and square steps.

Parameters:
- WIDTH, 6, bit width of base, modulus and result.
- EXP_WIDTH, 6, bit width of exponent; number of exponent bits scanned.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- base  input  WIDTH  operand; precondition base < modulus.
- exponent  input  EXP_WIDTH  exponent.
- modulus  input  WIDTH  modulus.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  final value; held until next start.
- count  output  EXP_WIDTH  index of exponent bit being processed (0 = LSB).

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, count=0, all internal registers 0. Reset mid-operation abandons it; there is no resume.
- Inputs are latched on the start-sampling edge (edge 0). Later input changes are ignored.
- start while busy or in DONE is ignored.
- States: IDLE, INIT, MUL, SQR, DONE.
- IDLE:
  - start=1 → INIT, busy=1.
  - Latch acc=1, b=base, e=exponent, n=modulus, count=0.
- INIT (1 cycle):
  - If n<2: result=0, go to DONE.
  - Otherwise, if e[0]=1 go to MUL, else go to SQR.
- MUL (WIDTH cycles): acc = acc*b mod n, then → SQR.
- SQR (WIDTH cycles): b = b*b mod n. Then:
  - If count==EXP_WIDTH-1: result=acc, go to DONE.
  - Otherwise: count+=1, shift e right, and go to MUL if the new e[0]=1, else SQR.
- DONE (1 cycle): done=1, busy=0, then → IDLE. done is never high for more than one cycle.
- Multiplier, one step per cycle for operand bit i from WIDTH-1 down to 0:
  - P = 2P; if a[i], P += m.
  - Then subtract n up to twice while P >= n.
  - P is WIDTH+2 bits wide, so nothing is truncated before reduction.
  - P is cleared at the start of each MUL or SQR.
- Latency: done rises on edge N = 1 + WIDTH*(EXP_WIDTH + popcount(exponent)) for n>=2, and on edge 1 for n<2.
- busy falls on edge N, the same edge on which done rises.
- exponent=0 with n>=2 gives result=1. All SQR steps are still executed.
- base>=modulus is outside contract; the result is unspecified but the engine must still terminate with the same latency.

Optional Feature:
- Macro: EARLY_EXIT_EN.
- Defined:
  - Before dispatching the next bit (in INIT and after each SQR), if the remaining shifted e == 0 → result=acc, go to DONE.
  - N = 1 + WIDTH*(k + popcount), where k = index of the highest set bit + 1 (k=0 for exponent=0).
  - count stops at the last processed bit.
- Not defined: all EXP_WIDTH bits are always scanned, with fixed latency as above (constant-time w.r.t. exponent zero-MSBs).

Test Plan:
- base=4, exponent=13, modulus=33, pulse start → done on edge 55 (no macro), result=31, busy high edges 0..54; count steps 0→5.
- base=5, exponent=0, modulus=7 → result=1, done on edge 37 (no macro); with EARLY_EXIT_EN done on edge 1, result=1.
- base=4, exponent=13, modulus=33 with EARLY_EXIT_EN → result=31, done on edge 43, final count=3.
- modulus=1, any base/exponent → result=0, done on edge 1; modulus=0 likewise.
- Assert reset at edge 20 of a base=4, exponent=13, modulus=33 run → busy=0, result=0, count=0 immediately. Restart with base=2, exponent=10, modulus=31 → result=1, done on edge 1+6*(6+2)=49.
- Pulse start again at edge 10 during a run → ignored: the original result and timing are unchanged, and there is no extra done pulse.
